// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential add/sub/shift-add-multiply ALU with ready/valid handshake; ALU_MUL_EN enables the multiplier
module alu_seq_core #(
    parameter int WIDTH       = 32,
    parameter int ADD_LATENCY = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_alu_a,
    input  logic [WIDTH-1:0] i_alu_b,
    input  logic [1:0]       i_alu_op,
    output logic             o_alu_ready,
    output logic             o_alu_res_valid,
    output logic [WIDTH-1:0] o_alu_result
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_MUL = 2'd3;
    localparam int CW = $clog2(WIDTH + 16);
    state_t state, state_nx;
    logic [CW-1:0] cnt, lat;
    logic [WIDTH-1:0] a_r, b_r, res_nx, mul_res;
    logic [1:0] op_r;
    logic accept, last;
    assign o_alu_ready     = state != BUSY;
    assign o_alu_res_valid = state == DONE;
    assign accept          = o_alu_ready && i_alu_op != OP_NOP;
    assign last            = state == BUSY && cnt == CW'(1);
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] acc, acc_nx;
    assign acc_nx  = acc + (b_r[0] ? a_r : '0);
    assign mul_res = acc_nx;
    assign lat     = i_alu_op == OP_MUL ? CW'(WIDTH) : CW'(ADD_LATENCY);
`else
    assign mul_res = '0;
    assign lat     = CW'(ADD_LATENCY);
`endif
    // next state and final result selection
    always_comb begin
        state_nx = state == BUSY ? (last ? DONE : BUSY) : (accept ? BUSY : IDLE);
        res_nx   = op_r == OP_ADD ? a_r + b_r :
                   op_r == OP_SUB ? a_r - b_r : mul_res;
    end
    // state, operand capture, latency countdown, multiply step and result register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            a_r          <= '0;
            b_r          <= '0;
            op_r         <= OP_NOP;
            o_alu_result <= '0;
`ifdef ALU_MUL_EN
            acc          <= '0;
`endif
        end else begin
            state <= state_nx;
            if (accept) begin
                a_r  <= i_alu_a;
                b_r  <= i_alu_b;
                op_r <= i_alu_op;
                cnt  <= lat;
`ifdef ALU_MUL_EN
                acc  <= '0;
`endif
            end else if (state == BUSY) begin
                cnt <= cnt - CW'(1);
`ifdef ALU_MUL_EN
                if (op_r == OP_MUL) begin
                    acc <= acc_nx;
                    a_r <= a_r << 1;
                    b_r <= b_r >> 1;
                end
`endif
                if (last)
                    o_alu_result <= res_nx;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: self-checking bench for alu_seq_core (directed table, corner sequences, random ops vs model)
module tb_alu_seq_core;
    logic        clk, rst;
    logic [31:0] i_a, i_b;
    logic [1:0]  i_op;
    logic        ready, valid;
    logic [31:0] result;
    int checks = 0;
    int failures = 0;

    alu_seq_core #(.WIDTH(32), .ADD_LATENCY(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_alu_a(i_a), .i_alu_b(i_b), .i_alu_op(i_op),
        .o_alu_ready(ready), .o_alu_res_valid(valid), .o_alu_result(result)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1;
`else
    localparam bit MUL_EN = 0;
`endif

    function automatic logic [31:0] model_res(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        if (op == 2'd1) return a + b;
        if (op == 2'd2) return a - b;
        return MUL_EN ? p[31:0] : 32'd0;
    endfunction

    function automatic int model_lat(logic [1:0] op);
        return (op == 2'd3 && MUL_EN) ? 32 : 1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input string name);
        int lat;
        @(negedge clk);
        i_op = op; i_a = a; i_b = b;
        @(posedge clk); #1;
        i_op = 2'd0; i_a = $urandom; i_b = $urandom;
        check({name, "_valid_after_accept"}, 32'(valid), 32'd0);
        lat = 0;
        while (ready !== 1'b1 && lat < 100) begin
            lat++;
            @(posedge clk); #1;
            if (ready !== 1'b1) begin
                i_a = $urandom; i_b = $urandom;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_valid"}, 32'(valid), 32'd1);
        check({name, "_result"}, result, exp_res);
    endtask

    vec_t vecs[6];
    logic [31:0] last_res;

    initial begin
        rst = 1; i_op = 0; i_a = 0; i_b = 0;
        vecs[0] = '{2'd1, 32'd5, 32'd7, 32'd12, 1};
        vecs[1] = '{2'd1, 32'hFFFFFFFF, 32'd1, 32'd0, 1};
        vecs[2] = '{2'd2, 32'd3, 32'd5, 32'hFFFFFFFE, 1};
`ifdef ALU_MUL_EN
        vecs[3] = '{2'd3, 32'd1234, 32'd5678, 32'd7006652, 32};
        vecs[4] = '{2'd3, 32'h10000, 32'h10000, 32'd0, 32};
        vecs[5] = '{2'd3, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 32};
`else
        vecs[3] = '{2'd3, 32'd1234, 32'd5678, 32'd0, 1};
        vecs[4] = '{2'd3, 32'h10000, 32'h10000, 32'd0, 1};
        vecs[5] = '{2'd3, 32'hFFFFFFFF, 32'd3, 32'd0, 1};
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_result", result, 32'd0);

        for (int i = 0; i < 6; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat, $sformatf("vec%0d", i));

        // NOP after DONE: valid drops, result held
        last_res = result;
        @(posedge clk); #1;
        check("nop_after_done_valid", 32'(valid), 32'd0);
        check("nop_after_done_result", result, last_res);

        // NOP held in IDLE
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle_nop_ready", 32'(ready), 32'd1);
            check("idle_nop_valid", 32'(valid), 32'd0);
        end

        // back-to-back random ADDs
        for (int i = 0; i < 32; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            do_op(2'd1, a, b, model_res(2'd1, a, b), 1, "rand_add");
        end

        // random mixed ops
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            logic [1:0] op;
            a = $urandom; b = $urandom; op = 2'($urandom_range(1, 3));
            do_op(op, a, b, model_res(op, a, b), model_lat(op), "rand_mix");
        end

        // reset in the middle of a MUL
        @(negedge clk);
        i_op = 2'd3; i_a = 32'd1234; i_b = 32'd5678;
        @(posedge clk); #1;
        i_op = 2'd0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("rst_mid_ready", 32'(ready), 32'd1);
        check("rst_mid_valid", 32'(valid), 32'd0);
        check("rst_mid_result", result, 32'd0);
        begin
            int late = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (valid !== 1'b0 || ready !== 1'b1) late++;
            end
            check("rst_mid_no_late_valid", 32'(late), 32'd0);
        end

        // operation after reset still works
        do_op(2'd2, 32'd100, 32'd1, 32'd99, 1, "post_rst_sub");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
